// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU four-phase memory handshake
// (memEn / R_W / MFC). A request is accepted from IDLE and its command,
// address and write data are latched at that point. The responder then waits
// WAIT_CYCLES cycles, performs one read or one write on the internal RAM and
// raises MFC. MFC is held until the initiator drops memEn.
//
// Parameters
//   ADDR_W       address width (MAR width)
//   DATA_W       data word width (MDR width)
//   DEPTH        implemented words, must be <= 2**ADDR_W
//   WAIT_CYCLES  wait states before the access, 0..15
//
// Ports
//   clk      in   rising-edge system clock
//   reset    in   synchronous reset, active-low (0 = reset)
//   memEn    in   request strobe, held by the initiator until MFC is seen
//   R_W      in   1 = read, 0 = write (sampled at acceptance)
//   addr     in   word address from MAR (sampled at acceptance)
//   dataIn   in   write data from MDR (sampled at acceptance)
//   dataOut  out  registered read data to MDR
//   MFC      out  registered memory-function-complete
//   busy     out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memEn,
    input  logic              R_W,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              MFC,
    output logic              busy
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam bit              NO_WAIT  = (WAIT_CYCLES == 0);
    // Value of cnt on the last wait cycle; unused when there are no wait states.
    localparam logic [3:0]      CNT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dataout_q, dataout_d;
    logic                mfc_q, mfc_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   ram_q [0:DEPTH-1];

    // Access command for the current edge (live inputs when there are no wait states).
    logic                acc_s;
    logic                acc_rw_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_data_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    idx_s;
    logic                wr_en_s;
    logic [DATA_W-1:0]   rd_data_s;

    // Next-state, access decode and output next-values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_s      = 1'b0;
        acc_rw_s   = rw_q;
        acc_addr_s = addr_q;
        acc_data_s = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (memEn) begin
                    rw_d    = R_W;
                    addr_d  = addr;
                    wdata_d = dataIn;
                    cnt_d   = 4'd0;
                    if (NO_WAIT) begin
                        // Zero wait states: the access happens on the accepting edge.
                        state_d    = ST_ACK;
                        acc_s      = 1'b1;
                        acc_rw_s   = R_W;
                        acc_addr_s = addr;
                        acc_data_s = dataIn;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!memEn) begin
                    // Aborted request: no access, no MFC.
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACK;
                    acc_s   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACK: begin
                if (!memEn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Addresses beyond DEPTH read as zero and drop writes.
        in_range_s = ({1'b0, acc_addr_s} < DEPTH_L);
        idx_s      = acc_addr_s[IDX_W-1:0];
        wr_en_s    = reset && acc_s && !acc_rw_s && in_range_s;
        rd_data_s  = in_range_s ? ram_q[idx_s] : {DATA_W{1'b0}};

        if (acc_s && acc_rw_s) begin
            dataout_d = rd_data_s;
        end else begin
            dataout_d = dataout_q;
        end

        // MFC follows ACK one edge later and falls on the edge that sees memEn low.
        mfc_d  = (state_q == ST_ACK) && memEn;
        busy_d = (state_d != ST_IDLE);
    end

    // Handshake FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rw_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            dataout_q <= {DATA_W{1'b0}};
            mfc_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dataout_q <= dataout_d;
            mfc_q     <= mfc_d;
            busy_q    <= busy_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_q[idx_s] <= acc_data_s;
        end
    end

    assign dataOut = dataout_q;
    assign MFC     = mfc_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (WAIT_CYCLES=2, WAIT_CYCLES=0,
// DEPTH=128) share clock, reset and request fields; each has its own memEn.
// Expected read data is pushed to a queue when a read is issued and popped
// when MFC is observed.
module tb_mem_responder;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        memEn_v;
    logic              R_W;
    logic [7:0]        addr;
    logic [15:0]       dataIn;
    logic [2:0][15:0]  dout_v;
    logic [2:0]        mfc_v;
    logic [2:0]        busy_v;

    int                checks = 0;
    int                errors = 0;
    logic [15:0]       exp_q[$];
    logic [15:0]       mdl [3][256];
    int                dep [3] = '{256, 256, 128};
    logic [15:0]       last_rd [3];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_wc2 (
        .clk(clk), .reset(reset), .memEn(memEn_v[0]), .R_W(R_W), .addr(addr),
        .dataIn(dataIn), .dataOut(dout_v[0]), .MFC(mfc_v[0]), .busy(busy_v[0]));

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_wc0 (
        .clk(clk), .reset(reset), .memEn(memEn_v[1]), .R_W(R_W), .addr(addr),
        .dataIn(dataIn), .dataOut(dout_v[1]), .MFC(mfc_v[1]), .busy(busy_v[1]));

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_CYCLES(2)) u_d128 (
        .clk(clk), .reset(reset), .memEn(memEn_v[2]), .R_W(R_W), .addr(addr),
        .dataIn(dataIn), .dataOut(dout_v[2]), .MFC(mfc_v[2]), .busy(busy_v[2]));

    // Full handshake on instance sel. Returns edges from acceptance to MFC
    // (-1 on timeout), dataOut while MFC is high, and hold/drop observations.
    task automatic handshake(input int sel, input logic rw, input logic [7:0] a,
                             input logic [15:0] d, input int hold, output int lat,
                             output logic [15:0] rdata, output logic held_ok,
                             output logic drop_ok);
        @(negedge clk);
        memEn_v[sel] = 1'b1;
        R_W          = rw;
        addr         = a;
        dataIn       = d;
        if (rw) begin
            exp_q.push_back((int'(a) < dep[sel]) ? mdl[sel][a] : 16'h0000);
        end else if (int'(a) < dep[sel]) begin
            mdl[sel][a] = d;
        end
        @(posedge clk);
        #1;
        // Fields must be ignored after acceptance.
        R_W    = ~rw;
        addr   = ~a;
        dataIn = ~d;
        lat    = -1;
        for (int n = 0; n < 20; n++) begin
            if (mfc_v[sel] === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        rdata   = dout_v[sel];
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (mfc_v[sel] !== 1'b1) held_ok = 1'b0;
        end
        @(negedge clk);
        memEn_v[sel] = 1'b0;
        @(posedge clk);
        #1;
        drop_ok = (mfc_v[sel] === 1'b0) && (busy_v[sel] === 1'b0);
        if (rw) last_rd[sel] = rdata;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        memEn_v = 3'b111;
        R_W     = 1'b0;
        addr    = 8'h00;
        dataIn  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (mfc_v[s] !== 1'b0 || busy_v[s] !== 1'b0 || dout_v[s] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state[%0d]: MFC=%b busy=%b dataOut=%h, expected 0/0/0000",
                         s, mfc_v[s], busy_v[s], dout_v[s]);
            end
        end
        @(negedge clk);
        reset   = 1'b1;
        memEn_v = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if (busy_v !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b expected 000", busy_v);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic hok, dok; logic [15:0] e;
        handshake(0, 1'b0, 8'h10, 16'hBEEF, 0, lat, rd, hok, dok);
        checks++;
        if (lat !== 3 || dok !== 1'b1) begin
            errors++;
            $display("FAIL write_latency: lat=%0d drop_ok=%b, expected 3/1", lat, dok);
        end
        handshake(0, 1'b1, 8'h10, 16'h0000, 0, lat, rd, hok, dok);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 3 || dok !== 1'b1) begin
            errors++;
            $display("FAIL read_latency: lat=%0d drop_ok=%b, expected 3/1", lat, dok);
        end
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_hold();
        int lat; logic [15:0] rd; logic hok, dok; logic [15:0] e;
        handshake(0, 1'b0, 8'h11, 16'h5A5A, 5, lat, rd, hok, dok);
        checks++;
        if (lat !== 3 || hok !== 1'b1 || dok !== 1'b1) begin
            errors++;
            $display("FAIL hold_mfc: lat=%0d held=%b drop_ok=%b, expected 3/1/1", lat, hok, dok);
        end
        handshake(0, 1'b1, 8'h11, 16'h0000, 0, lat, rd, hok, dok);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL hold_readback: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_abort();
        int lat; logic [15:0] rd; logic hok, dok; logic [15:0] e; logic quiet;
        handshake(0, 1'b0, 8'h20, 16'h1111, 0, lat, rd, hok, dok);
        @(negedge clk);
        memEn_v[0] = 1'b1;
        R_W        = 1'b0;
        addr       = 8'h20;
        dataIn     = 16'h1234;
        @(posedge clk);
        #1;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept: busy=%b expected 1", busy_v[0]);
        end
        @(negedge clk);
        memEn_v[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || mfc_v[0] !== 1'b0 || dout_v[0] !== last_rd[0]) begin
            errors++;
            $display("FAIL abort_idle: busy=%b MFC=%b dataOut=%h, expected 0/0/%h",
                     busy_v[0], mfc_v[0], dout_v[0], last_rd[0]);
        end
        quiet = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mfc_v[0] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_mfc: MFC rose after abort");
        end
        handshake(0, 1'b1, 8'h20, 16'h0000, 0, lat, rd, hok, dok);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL abort_ram_unchanged: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd; logic hok, dok; logic [15:0] e;
        handshake(1, 1'b0, 8'h01, 16'hA001, 0, lat, rd, hok, dok);
        handshake(1, 1'b0, 8'h02, 16'hA002, 0, lat, rd, hok, dok);
        checks++;
        if (lat !== 1 || dok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write: lat=%0d drop_ok=%b, expected 1/1", lat, dok);
        end
        for (int i = 1; i <= 2; i++) begin
            handshake(1, 1'b1, 8'(i), 16'h0000, 0, lat, rd, hok, dok);
            e = exp_q.pop_front();
            checks++;
            if (lat !== 1 || dok !== 1'b1 || rd !== e) begin
                errors++;
                $display("FAIL b2b_read@%0d: lat=%0d drop_ok=%b data=%h, expected 1/1/%h",
                         i, lat, dok, rd, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd; logic hok, dok; logic [15:0] e;
        logic [7:0]  a_tab [4] = '{8'h70, 8'hF0, 8'hF0, 8'hF0};
        logic        w_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] d_tab [4] = '{16'h7777, 16'h0000, 16'h9999, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            handshake(2, w_tab[i], a_tab[i], d_tab[i], 0, lat, rd, hok, dok);
            checks++;
            if (lat !== 3 || dok !== 1'b1) begin
                errors++;
                $display("FAIL oor_handshake[%0d]: lat=%0d drop_ok=%b, expected 3/1", i, lat, dok);
            end
            if (w_tab[i]) begin
                e = exp_q.pop_front();
                checks++;
                if (rd !== e) begin
                    errors++;
                    $display("FAIL oor_read[%0d]: got %h expected %h", i, rd, e);
                end
            end
        end
        // An out-of-range write must not alias onto the low half.
        handshake(2, 1'b1, 8'h70, 16'h0000, 0, lat, rd, hok, dok);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin
            errors++;
            $display("FAIL oor_no_alias: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_reset_in_ack();
        int lat; logic [15:0] e;
        @(negedge clk);
        memEn_v[2] = 1'b1;
        R_W        = 1'b1;
        addr       = 8'h70;
        exp_q.push_back(mdl[2][8'h70]);
        @(posedge clk);
        #1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (mfc_v[2] === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (lat !== 3 || dout_v[2] !== e) begin
            errors++;
            $display("FAIL rst_ack_pre: lat=%0d data=%h, expected 3/%h", lat, dout_v[2], e);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mfc_v[2] !== 1'b0 || busy_v[2] !== 1'b0 || dout_v[2] !== 16'h0000) begin
            errors++;
            $display("FAIL rst_in_ack: MFC=%b busy=%b dataOut=%h, expected 0/0/0000",
                     mfc_v[2], busy_v[2], dout_v[2]);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(mdl[2][8'h70]);
        @(posedge clk);
        #1;
        checks++;
        if (busy_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_reaccept: busy=%b expected 1", busy_v[2]);
        end
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (mfc_v[2] === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (lat !== 3 || dout_v[2] !== e) begin
            errors++;
            $display("FAIL rst_reaccept_read: lat=%0d data=%h, expected 3/%h", lat, dout_v[2], e);
        end
        @(negedge clk);
        memEn_v[2] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mfc_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_final_drop: MFC=%b expected 0", mfc_v[2]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_abort();
        test_back_to_back();
        test_out_of_range();
        test_reset_in_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
